// File: rtl/psmac_pkg.sv
// Shared encodings for the partial-slice MAC accumulator: product sign modes,
// accumulator control states and the default accumulator width.
package psmac_pkg;

    localparam int ACC_W_DEF = 24;

    typedef enum logic [1:0] {
        SEL_UU = 2'b00,
        SEL_US = 2'b01,
        SEL_SU = 2'b10,
        SEL_SS = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/psmac_shext.sv
// Places a 4-bit slice product at its weight: extend to ACC_W according to the
// sign mode, then shift left by two bits per weight index.
module psmac_shext
    import psmac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [3:0]       i_p,
    input  logic [1:0]       i_sel,
    input  logic [2:0]       i_k,
    output logic [ACC_W-1:0] o_val
);

    logic [ACC_W-1:0] w_ext;
    logic             w_fill;

    // Only an unsigned-by-unsigned product is non-negative by construction.
    assign w_fill = (i_sel == SEL_UU) ? 1'b0 : i_p[3];
    assign w_ext  = {{(ACC_W-4){w_fill}}, i_p};
    assign o_val  = w_ext << {i_k, 1'b0};

endmodule

// File: rtl/psmac_acc.sv
// Accumulates weighted slice products into a two's-complement sum and hands the
// finished sum downstream with a valid/ready handshake.
module psmac_acc
    import psmac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_p,
    input  logic [1:0]       in_sel,
    input  logic [2:0]       in_k,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [4:0]       out_beats
);

    state_e           r_state;
    state_e           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_beat_val;
    logic [4:0]       r_beats;
    logic [4:0]       w_beats_next;
    logic [4:0]       w_beats_inc;
    logic             w_done;
    logic             w_ready;
    logic             w_accept;

    psmac_shext #(
        .ACC_W (ACC_W)
    ) u_shext (
        .i_p   (in_p),
        .i_sel (in_sel),
        .i_k   (in_k),
        .o_val (w_beat_val)
    );

    assign w_done      = (r_state == ST_DONE);
    assign w_ready     = !w_done || out_ready;
    assign w_accept    = in_valid && w_ready;
    assign w_beats_inc = (r_beats == 5'd31) ? 5'd31 : r_beats + 5'd1;

    assign in_ready  = w_ready;
    assign out_valid = w_done;
    assign out_acc   = r_acc;
    assign out_beats = r_beats;

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_beats_next = r_beats;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    w_acc_next   = r_acc + w_beat_val;
                    w_beats_next = w_beats_inc;
                    w_state_next = in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                // A beat arriving while the result drains seeds the next sum.
                if (out_ready) begin
                    if (w_accept) begin
                        w_acc_next   = w_beat_val;
                        w_beats_next = 5'd1;
                        w_state_next = in_last ? ST_DONE : ST_ACCUM;
                    end else begin
                        w_acc_next   = '0;
                        w_beats_next = 5'd0;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_acc_next   = '0;
                w_beats_next = 5'd0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_beats <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_beats <= w_beats_next;
        end
    end

endmodule

// File: tb/tb_psmac_acc.sv
// Directed and randomized checks of psmac_acc (24-bit and 16-bit instances)
// against an integer-arithmetic reference of the weighted-sum rules.
module tb_psmac_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_p;
    logic [1:0]  in_sel;
    logic [2:0]  in_k;
    logic        in_last;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_acc;
    logic [4:0]  out_beats;
    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] out_acc16;
    logic [4:0]  out_beats16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    psmac_acc #(.ACC_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_sel    (in_sel),
        .in_k      (in_k),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_beats (out_beats)
    );

    psmac_acc #(.ACC_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready16),
        .in_p      (in_p),
        .in_sel    (in_sel),
        .in_k      (in_k),
        .in_last   (in_last),
        .out_valid (out_valid16),
        .out_ready (out_ready),
        .out_acc   (out_acc16),
        .out_beats (out_beats16)
    );

    // Reference: exact integer sum of signed/unsigned product times 4^k.
    longint m_acc   = 0;
    int     m_beats = 0;
    logic   m_valid = 1'b0;

    function automatic longint beat_value(logic [3:0] p, logic [1:0] sel, logic [2:0] k);
        longint v;
        v = longint'(p);
        if (sel != 2'b00 && v >= 8) v = v - 16;
        return v * (longint'(1) << (2 * int'(k)));
    endfunction

    wire m_rdy    = !m_valid || out_ready;
    wire m_accept = in_valid && m_rdy;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_acc   <= 0;
            m_beats <= 0;
            m_valid <= 1'b0;
        end else if (m_accept) begin
            if (m_valid) begin
                m_acc   <= beat_value(in_p, in_sel, in_k);
                m_beats <= 1;
            end else begin
                m_acc   <= m_acc + beat_value(in_p, in_sel, in_k);
                m_beats <= (m_beats >= 31) ? 31 : m_beats + 1;
            end
            m_valid <= in_last;
        end else if (m_valid && out_ready) begin
            m_acc   <= 0;
            m_beats <= 0;
            m_valid <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [23:0] e24;
        logic [15:0] e16;
        e24 = m_acc[23:0];
        e16 = m_acc[15:0];
        chk({tag, "_valid"},    32'(out_valid),   32'(m_valid));
        chk({tag, "_ready"},    32'(in_ready),    32'(m_rdy));
        chk({tag, "_acc"},      32'(out_acc),     32'(e24));
        chk({tag, "_beats"},    32'(out_beats),   32'(m_beats));
        chk({tag, "_acc16"},    32'(out_acc16),   32'(e16));
        chk({tag, "_valid16"},  32'(out_valid16), 32'(m_valid));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic set_beat(input logic v, input logic [3:0] p, input logic [1:0] sel,
                            input logic [2:0] k, input logic last);
        in_valid = v;
        in_p     = p;
        in_sel   = sel;
        in_k     = k;
        in_last  = last;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_beat(1'b1, 4'd5, 2'b00, 3'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        check_model("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_acc", 32'(out_acc), 32'h0);

        // Single unsigned beat, latency 1.
        set_beat(1'b1, 4'b1001, 2'b00, 3'd0, 1'b1);
        tick("uu9");
        chk("uu9_acc", 32'(out_acc), 32'h000009);
        chk("uu9_beats", 32'(out_beats), 32'd1);
        chk("uu9_valid", 32'(out_valid), 32'd1);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("uu9_drain");
        chk("uu9_drain_valid", 32'(out_valid), 32'd0);

        // Signed -1 at weight 16.
        set_beat(1'b1, 4'b1111, 2'b11, 3'd2, 1'b1);
        tick("ss");
        chk("ss_acc", 32'(out_acc), 32'hFFFFF0);
        chk("ss_acc16", 32'(out_acc16), 32'hFFF0);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("ss_drain");

        // 255*255 from sixteen 3x3 slice products.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                set_beat(1'b1, 4'b1001, 2'b00, 3'(i + j), (i == 3 && j == 3));
                tick("dot");
            end
        end
        chk("dot_acc", 32'(out_acc), 32'h00FE01);
        chk("dot_beats", 32'(out_beats), 32'd16);

        // Backpressure: result held while a beat waits.
        out_ready = 1'b0;
        set_beat(1'b1, 4'b0001, 2'b00, 3'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick("stall");
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_acc", 32'(out_acc), 32'h00FE01);
        end
        out_ready = 1'b1;
        tick("restart");
        chk("restart_acc", 32'(out_acc), 32'h000001);
        chk("restart_beats", 32'(out_beats), 32'd1);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("restart_drain");

        // Reset in the middle of an accumulation.
        for (int c = 0; c < 3; c++) begin
            set_beat(1'b1, 4'd3, 2'b00, 3'd1, 1'b0);
            tick("pre_rst");
        end
        rst_n = 1'b0;
        tick("mid_rst");
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_acc", 32'(out_acc), 32'h0);
        rst_n = 1'b1;
        set_beat(1'b1, 4'b0010, 2'b00, 3'd0, 1'b1);
        tick("post_rst");
        chk("post_rst_acc", 32'(out_acc), 32'h000002);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("post_rst_drain");

        // 16-bit wrap.
        set_beat(1'b1, 4'b1111, 2'b00, 3'd6, 1'b0);
        tick("wrap1");
        set_beat(1'b1, 4'b1111, 2'b00, 3'd6, 1'b1);
        tick("wrap2");
        chk("wrap_acc16", 32'(out_acc16), 32'hE000);
        chk("wrap_acc24", 32'(out_acc), 32'h01E000);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("wrap_drain");

        // Beat count saturation.
        for (int c = 0; c < 36; c++) begin
            set_beat(1'b1, 4'd1, 2'b00, 3'd0, (c == 35));
            tick("sat");
        end
        chk("sat_beats", 32'(out_beats), 32'd31);
        chk("sat_acc", 32'(out_acc), 32'd36);
        set_beat(1'b0, 4'd0, 2'b00, 3'd0, 1'b0);
        tick("sat_drain");

        // Randomized traffic with random backpressure and rare resets.
        for (int c = 0; c < 400; c++) begin
            set_beat(($urandom % 4) != 0, 4'($urandom), 2'($urandom), 3'($urandom),
                     ($urandom % 8) == 0);
            out_ready = ($urandom % 3) != 0;
            rst_n     = ($urandom % 100) != 0;
            tick("rand");
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psmac_acc.md
PSMAC_ACC -- requirements
Module: psmac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator and result width in bits (legal range 16..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, upstream product beat valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a beat this cycle.
REQ-006 SHALL have port in_p, input, 4, 2x2 slice product from the multiplier functional unit.
REQ-007 SHALL have port in_sel, input, 2, mode of that product: 00 UU, 01 US, 10 SU, 11 SS.
REQ-008 SHALL have port in_k, input, 3, slice weight index; product weight is 2^(2*in_k).
REQ-009 SHALL have port in_last, input, 1, beat is the final beat of the current dot/product.
REQ-010 SHALL have port out_valid, output, 1, result available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port out_acc, output, ACC_W, accumulated two's-complement result.
REQ-013 SHALL have port out_beats, output, 5, number of beats folded into out_acc, saturating at 31.

Function
REQ-014 A beat SHALL be accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-015 in_ready SHALL equal (!out_valid || out_ready).
REQ-016 Accepted in_p SHALL be zero-extended to ACC_W when in_sel=UU, otherwise sign-extended from bit 3.
REQ-017 The extended value SHALL be shifted left by 2*in_k, bits above ACC_W discarded.
REQ-018 The shifted value SHALL be added to the accumulator modulo 2^ACC_W (wrap, no saturation, no flag).
REQ-019 States SHALL be IDLE (acc=0, beats=0), ACCUM (one or more beats, no last seen), DONE (out_valid=1).
REQ-020 IDLE/ACCUM with accepted beat and in_last=0 -> ACCUM; with in_last=1 -> DONE.
REQ-021 DONE with out_ready=0 SHALL hold out_acc, out_beats and out_valid unchanged and accept no beat.
REQ-022 DONE with out_ready=1 and no accepted beat -> IDLE, accumulator and beat count cleared.
REQ-023 DONE with out_ready=1 and an accepted beat SHALL start a new accumulation from zero with that beat (-> ACCUM, or DONE if in_last=1), beat count 1.
REQ-024 A beat with in_last=1 SHALL become visible on out_acc with out_valid=1 in the cycle after acceptance (latency 1).
REQ-025 Beats not accepted (in_valid=0) SHALL leave all state unchanged.
REQ-026 out_beats SHALL increment per accepted beat and stick at 31.

Reset
REQ-027 When rst_n=0 at a clock edge, state SHALL become IDLE, accumulator 0, beat count 0, out_valid 0, regardless of in-flight beats or a pending result.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-029 Package psmac_pkg SHALL hold sel encodings UU/US/SU/SS, the state enumeration and ACC_W default.
REQ-030 Sub-module psmac_shext SHALL perform the extend-and-shift of REQ-016/017 combinationally; psmac_acc instantiates it once.

Verification
REQ-031 UU in_p=1001 (9), k=0, last -> out_acc=0x000009, out_beats=1, out_valid next cycle.
REQ-032 SS in_p=1111, k=2, last -> out_acc=0xFFFFF0 (-16).
REQ-033 16 UU beats of in_p=1001 (slice product 3x3) with k=i+j, i,j in 0..3, last on 16th -> out_acc=0x00FE01 (255*255), out_beats=16.
REQ-034 Result in DONE, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_acc stable; then out_ready=1 with beat UU 0001 k=0 last -> next result 0x000001.
REQ-035 Three beats accepted, rst_n=0 one cycle mid-sequence -> IDLE, out_valid=0; next single UU 0010 k=0 last -> 0x000002.
REQ-036 ACC_W=16, UU in_p=1111 k=6 twice, last -> out_acc=0xE000 (61440*2 mod 65536).
